// File: rtl/tst_resp_checker.sv
// tst_resp_checker: paces a vector source, strobes DUT outputs after a settle delay, masked-compares and logs failures
module tst_resp_checker #(
  parameter int NOUTPUTS   = 1,
  parameter int PAT_W      = 16,
  parameter int ERR_W      = 16,
  parameter int STROBE_DLY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                exp_valid,
  output logic                exp_ready,
  input  logic [NOUTPUTS-1:0] exp_data,
  input  logic [NOUTPUTS-1:0] exp_mask,
  input  logic                exp_last,
  input  logic                exp_end,
  input  logic [NOUTPUTS-1:0] dut_out,
  output logic                apply,
  output logic                miscompare,
  output logic [NOUTPUTS-1:0] miscompare_bits,
  output logic [ERR_W-1:0]    fail_cnt,
  output logic [PAT_W-1:0]    first_fail_pat,
  output logic [PAT_W-1:0]    first_fail_vec,
  output logic [PAT_W-1:0]    pattern_number,
  output logic [PAT_W-1:0]    vector_number,
  output logic                busy,
  output logic                done,
  output logic                pass
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_STROBE, S_DONE} state_t;
  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [NOUTPUTS-1:0] data_q, mask_q, bits_q, mism_d;
  logic                last_q, end_q, apply_q, misc_q, done_q, pass_q;
  logic [ERR_W-1:0]    fail_q, fail_d;
  logic [PAT_W-1:0]    pat_q, vec_q, ffp_q, ffv_q;
  assign exp_ready       = state_q == S_WAIT;
  assign busy            = state_q inside {S_WAIT, S_SETTLE, S_STROBE};
  assign apply           = apply_q;
  assign miscompare      = misc_q;
  assign miscompare_bits = bits_q;
  assign fail_cnt        = fail_q;
  assign first_fail_pat  = ffp_q;
  assign first_fail_vec  = ffv_q;
  assign pattern_number  = pat_q;
  assign vector_number   = vec_q;
  assign done            = done_q;
  assign pass            = pass_q;
  // masked compare of the captured vector against the live DUT outputs and the saturating fail count it implies
  always_comb begin
    mism_d = (dut_out ^ data_q) & mask_q;
    fail_d = (|mism_d && fail_q != '1) ? fail_q + ERR_W'(1) : fail_q;
  end
  // run sequencer: accept a vector, pulse apply, wait the settle delay, strobe and update the run statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      end_q   <= 1'b0;
      apply_q <= 1'b0;
      misc_q  <= 1'b0;
      bits_q  <= '0;
      fail_q  <= '0;
      ffp_q   <= '0;
      ffv_q   <= '0;
      pat_q   <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      apply_q <= 1'b0;
      misc_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q <= S_WAIT;
          bits_q  <= '0;
          fail_q  <= '0;
          ffp_q   <= '0;
          ffv_q   <= '0;
          pat_q   <= '0;
          vec_q   <= '0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
        S_WAIT: if (exp_valid) begin
          state_q <= S_SETTLE;
          data_q  <= exp_data;
          mask_q  <= exp_mask;
          last_q  <= exp_last;
          end_q   <= exp_end;
          apply_q <= 1'b1;
          cnt_q   <= 4'(STROBE_DLY - 1);
        end
        S_SETTLE: begin
          state_q <= cnt_q == '0 ? S_STROBE : S_SETTLE;
          cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
        end
        S_STROBE: begin
          bits_q  <= mism_d;
          misc_q  <= |mism_d;
          fail_q  <= fail_d;
          ffp_q   <= (|mism_d && fail_q == '0) ? pat_q : ffp_q;
          ffv_q   <= (|mism_d && fail_q == '0) ? vec_q : ffv_q;
          vec_q   <= vec_q + PAT_W'(1);
          pat_q   <= (last_q || end_q) ? pat_q + PAT_W'(1) : pat_q;
          state_q <= end_q ? S_DONE : S_WAIT;
          done_q  <= end_q;
          pass_q  <= end_q && fail_d == '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tst_resp_checker.sv
// tb_tst_resp_checker: randomized scoreboard bench for tst_resp_checker
module tb_tst_resp_checker;
  localparam int N = 3, PW = 4, EW = 3, SD = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, exp_valid = 1'b0, exp_last = 1'b0, exp_end = 1'b0;
  logic [N-1:0] exp_data = '0, exp_mask = '0, dut_out = '0;
  logic exp_ready, apply, miscompare, busy, done, pass;
  logic [N-1:0] miscompare_bits;
  logic [EW-1:0] fail_cnt;
  logic [PW-1:0] first_fail_pat, first_fail_vec, pattern_number, vector_number;
  int checks = 0, failures = 0, cyc = 0;
  bit mon_en = 1'b0;
  logic [PW-1:0] prev_vec = '0;
  typedef struct {logic misc; logic [N-1:0] bits; int fc, fp, fv, pat, vec; bit fin; int t;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int m_fail, m_ffp, m_ffv, m_pat, m_vec;

  tst_resp_checker #(.NOUTPUTS(N), .PAT_W(PW), .ERR_W(EW), .STROBE_DLY(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last), .exp_end(exp_end),
    .dut_out(dut_out), .apply(apply), .miscompare(miscompare), .miscompare_bits(miscompare_bits),
    .fail_cnt(fail_cnt), .first_fail_pat(first_fail_pat), .first_fail_vec(first_fail_vec),
    .pattern_number(pattern_number), .vector_number(vector_number),
    .busy(busy), .done(done), .pass(pass));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_apply"}, apply, 0);
    chk({tag, "_misc"}, miscompare, 0);
    chk({tag, "_bits"}, miscompare_bits, 0);
    chk({tag, "_fc"}, fail_cnt, 0);
    chk({tag, "_ffp"}, first_fail_pat, 0);
    chk({tag, "_ffv"}, first_fail_vec, 0);
    chk({tag, "_pat"}, pattern_number, 0);
    chk({tag, "_vec"}, vector_number, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_ready"}, exp_ready, 0);
  endtask

  // reference model: what the run statistics must read after this vector is strobed
  task automatic model_push(input logic [N-1:0] d, m, input bit l, e, input logic [N-1:0] o, input int t);
    exp_t x;
    logic [N-1:0] mm;
    mm = (o ^ d) & m;
    if (mm != 0) begin
      if (m_fail == 0) begin
        m_ffp = m_pat;
        m_ffv = m_vec;
      end
      if (m_fail < (1 << EW) - 1) m_fail++;
    end
    m_vec = (m_vec + 1) % (1 << PW);
    if (l || e) m_pat = (m_pat + 1) % (1 << PW);
    x = '{mm != 0, mm, m_fail, m_ffp, m_ffv, m_pat, m_vec, e, t};
    sb.push_back(x);
  endtask

  // monitor: every strobe shows up as a vector_number step (or a miscompare pulse)
  always @(negedge clk) begin
    if (mon_en && (vector_number != prev_vec || miscompare)) begin
      if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("strobe_cycle", cyc, mon_e.t);
        chk("miscompare", miscompare, mon_e.misc);
        chk("miscompare_bits", miscompare_bits, mon_e.bits);
        chk("fail_cnt", fail_cnt, mon_e.fc);
        chk("first_fail_pat", first_fail_pat, mon_e.fp);
        chk("first_fail_vec", first_fail_vec, mon_e.fv);
        chk("pattern_number", pattern_number, mon_e.pat);
        chk("vector_number", vector_number, mon_e.vec);
        chk("done", done, mon_e.fin);
        chk("pass", pass, mon_e.fin && mon_e.fc == 0);
        chk("busy", busy, !mon_e.fin);
      end
    end
    prev_vec = vector_number;
  end

  task automatic do_start();
    start = 1'b1;
    mon_en = 1'b0;
    m_fail = 0; m_ffp = 0; m_ffv = 0; m_pat = 0; m_vec = 0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    chk("start_fc", fail_cnt, 0);
    chk("start_vec", vector_number, 0);
    chk("start_pat", pattern_number, 0);
    chk("start_ffv", first_fail_vec, 0);
    chk("start_bits", miscompare_bits, 0);
    chk("start_ready", exp_ready, 1);
    #1 mon_en = 1'b1;
  endtask

  task automatic send_vec(input logic [N-1:0] d, m, input bit l, e, input logic [N-1:0] o);
    int w = 0;
    int t;
    exp_valid = 1'b1; exp_data = d; exp_mask = m; exp_last = l; exp_end = e;
    while (!exp_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!exp_ready) begin
      chk("ready_timeout", 0, 1);
      exp_valid = 1'b0;
      return;
    end
    t = cyc + 1;
    model_push(d, m, l, e, o, t + SD + 1);
    @(negedge clk);
    chk("apply_pulse", apply, 1);
    chk("ready_low", exp_ready, 0);
    dut_out = o;
    exp_valid = 1'($urandom);
    exp_data = N'($urandom); exp_mask = N'($urandom);
    exp_last = 1'($urandom); exp_end = 1'($urandom);
    start = $urandom_range(3, 0) == 0;
    @(negedge clk);
    chk("apply_end", apply, 0);
    exp_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("done_reached", done, 1);
    repeat (2) begin
      @(negedge clk);
      chk("done_ready", exp_ready, 0);
      chk("done_apply", apply, 0);
      chk("done_hold", done, 1);
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic run_random(input int n, input int errpct);
    logic [N-1:0] d, m, o;
    do_start();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      d = N'($urandom);
      m = $urandom_range(4, 0) == 0 ? '0 : N'($urandom);
      o = $urandom_range(99, 0) < errpct ? d ^ N'($urandom_range((1 << N) - 1, 1)) : d;
      send_vec(d, m, $urandom_range(2, 0) == 0, i == n - 1, o);
    end
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");
    // clean four-vector run, two patterns
    do_start();
    send_vec(3'd0, 3'd7, 0, 0, 3'd0);
    send_vec(3'd5, 3'd7, 1, 0, 3'd5);
    send_vec(3'd7, 3'd7, 0, 0, 3'd7);
    send_vec(3'd2, 3'd7, 1, 1, 3'd2);
    wait_done();
    chk("t1_pass", pass, 1);
    chk("t1_fc", fail_cnt, 0);
    chk("t1_vec", vector_number, 4);
    chk("t1_pat", pattern_number, 2);
    // same stream, third vector wrong
    do_start();
    send_vec(3'd0, 3'd7, 0, 0, 3'd0);
    send_vec(3'd5, 3'd7, 1, 0, 3'd5);
    send_vec(3'd7, 3'd7, 0, 0, 3'd6);
    send_vec(3'd2, 3'd7, 1, 1, 3'd2);
    wait_done();
    chk("t2_fc", fail_cnt, 1);
    chk("t2_ffp", first_fail_pat, 1);
    chk("t2_ffv", first_fail_vec, 2);
    chk("t2_pass", pass, 0);
    // mismatches hidden by the mask never fail; end without last still ends the pattern
    do_start();
    send_vec(3'd5, 3'd0, 0, 0, 3'd2);
    send_vec(3'd4, 3'd3, 0, 1, 3'd0);
    wait_done();
    chk("t3_pass", pass, 1);
    chk("t3_pat", pattern_number, 1);
    // saturation of the fail counter
    do_start();
    for (int i = 0; i < 9; i++) send_vec(3'd1, 3'd7, 0, i == 8, 3'd6);
    wait_done();
    chk("t4_fc", fail_cnt, 7);
    chk("t4_ffv", first_fail_vec, 0);
    // vector counter wraps
    do_start();
    for (int i = 0; i < 17; i++) send_vec(3'd2, 3'd7, 0, i == 16, 3'd2);
    wait_done();
    chk("t6_vec", vector_number, 1);
    for (int r = 0; r < 6; r++) run_random($urandom_range(24, 4), r * 20);
    // asynchronous reset while settling
    do_start();
    send_vec(3'd1, 3'd7, 0, 0, 3'd0);
    send_vec(3'd1, 3'd7, 1, 0, 3'd0);
    exp_valid = 1'b1; exp_data = 3'd3; exp_mask = 3'd7; exp_last = 1'b0; exp_end = 1'b0;
    for (int w = 0; w < 100 && !exp_ready; w++) @(negedge clk);
    chk("t5_ready", exp_ready, 1);
    @(negedge clk);
    chk("t5_apply", apply, 1);
    chk("t5_vec_before", vector_number, 2);
    exp_valid = 1'b0;
    #1 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("async_rst");
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_apply", apply, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    do_start();
    send_vec(3'd6, 3'd7, 1, 0, 3'd6);
    send_vec(3'd3, 3'd5, 0, 1, 3'd1);
    wait_done();
    chk("t5_pass", pass, 1);
    chk("t5_vec", vector_number, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
